// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//
// Purpose:
//   Shared constants and types for the clock datapath: default timebase
//   settings, the width of the seconds bus, and the BCD digit type used by the
//   display stage. A small binary-to-BCD helper is included so the display
//   stage can split a seconds value into two digits without its own divider.
//
// Contents:
//   CLK_HZ_DEFAULT       default system clock frequency (Hz)
//   SEC_PER_MIN_DEFAULT  default seconds per minute
//   SEC_W                width of the binary seconds bus (0..63)
//   bcd_digit_t          one BCD digit
//   bcd_pair_t           tens/ones digit pair
//   bin_to_bcd()         binary seconds value -> two BCD digits
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int CLK_HZ_DEFAULT      = 256;
    localparam int SEC_PER_MIN_DEFAULT = 60;
    localparam int SEC_W               = 6;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_pair_t;

    // Values up to 63 give a tens digit of at most 6, so both results fit
    // in a single BCD digit.
    function automatic bcd_pair_t bin_to_bcd(input logic [SEC_W-1:0] bin);
        bcd_pair_t          result;
        logic [SEC_W-1:0]   tens_bin;
        logic [SEC_W-1:0]   ones_bin;
        tens_bin    = bin / SEC_W'(10);
        ones_bin    = bin % SEC_W'(10);
        result.tens = tens_bin[3:0];
        result.ones = ones_bin[3:0];
        return result;
    endfunction

endpackage : clock_pkg

// File: rtl/mod_n_tick.sv
// -----------------------------------------------------------------------------
// mod_n_tick
//
// Purpose:
//   Generic modulo-N counter with count enable, synchronous clear and a
//   registered wrap pulse. The wrap pulse is high for exactly the cycle that
//   follows the edge on which the count rolled over from N-1 to 0.
//
// Parameters:
//   N        modulus (>= 2)
//   W        counter width, must hold N-1
//
// Ports:
//   clk      input   system clock, rising edge
//   reset_n  input   asynchronous active-low reset
//   en_i     input   advance the count on this edge
//   clr_i    input   force the count to 0; wins over en_i and kills the pulse
//   count_o  output  current count, 0..N-1 (registered)
//   wrap_o   output  single-cycle wrap pulse (registered)
// -----------------------------------------------------------------------------
module mod_n_tick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         wrap_q;
    logic         wrap_d;
    logic         at_last;

    assign at_last = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            wrap_d  = at_last;
            count_d = at_last ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;

endmodule : mod_n_tick

// File: rtl/minute_tick_gen.sv
// -----------------------------------------------------------------------------
// minute_tick_gen
//
// Purpose:
//   Timebase for the clock datapath. Divides the system clock into a 1 Hz
//   tick (one_second) and a one-minute tick (one_minute), and tracks the
//   seconds within the current minute. A fast-watch mode turns every second
//   tick into a minute tick so the minute/hour counters can be exercised
//   quickly. sec_clr re-aligns the prescaler and seconds when a new time is
//   loaded.
//
// Parameters:
//   CLK_HZ       system clock frequency in Hz (>= 2)
//   SEC_PER_MIN  seconds per minute (>= 2, <= 64)
//   PRESC_W      prescaler width, derived from CLK_HZ
//
// Ports:
//   clk          input   system clock, rising edge
//   reset_n      input   asynchronous active-low reset
//   fast_watch   input   level, 1 = one minute per second
//   sec_clr      input   synchronous clear of prescaler and seconds
//   one_second   output  single-cycle pulse every CLK_HZ cycles
//   one_minute   output  single-cycle pulse once per minute
//                        (once per second in fast mode)
//   seconds      output  current seconds, binary, 0..SEC_PER_MIN-1
//
// Build option:
//   MINUTE_TICK_GEN_SYNC_EN  when defined, fast_watch is passed through a
//                            two-flop synchronizer before the mode register
//                            (mode latency 3 cycles instead of 1).
// -----------------------------------------------------------------------------
module minute_tick_gen
    import clock_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int SEC_PER_MIN = SEC_PER_MIN_DEFAULT,
    parameter int PRESC_W     = $clog2(CLK_HZ)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fast_watch,
    input  logic             sec_clr,
    output logic             one_second,
    output logic             one_minute,
    output logic [SEC_W-1:0] seconds
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    // ------------------------------------------------------------------
    // Mode input path
    // ------------------------------------------------------------------
    logic fast_src;     // value the mode register loads on the next edge
    logic fast_q;       // registered mode, 1 = fast
    logic mode_change;  // fast_q flips on the coming edge

`ifdef MINUTE_TICK_GEN_SYNC_EN
    // fast_watch may come straight from a switch, so it is treated as
    // asynchronous and resolved through two flops before use.
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], fast_watch};
        end
    end

    assign fast_src = sync_q[1];
`else
    assign fast_src = fast_watch;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fast_q <= 1'b0;
        end else begin
            fast_q <= fast_src;
        end
    end

    assign mode_change = fast_src ^ fast_q;

    // ------------------------------------------------------------------
    // Prescaler: clk -> 1 Hz
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_count;
    logic               presc_last;   // this edge is a second tick (if not cleared)

    mod_n_tick #(
        .N (CLK_HZ),
        .W (PRESC_W)
    ) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (1'b1),
        .clr_i   (sec_clr),
        .count_o (presc_count),
        .wrap_o  (one_second)
    );

    assign presc_last = (presc_count == PRESC_LAST);

    // ------------------------------------------------------------------
    // Seconds counter
    // ------------------------------------------------------------------
    // Held at 0 throughout fast mode, and cleared on the edge where the
    // mode flips. A minute that would have completed on the very edge of a
    // normal->fast switch is discarded along with the partial count.
    logic sec_clr_all;
    logic sec_wrap;

    assign sec_clr_all = sec_clr | fast_q | mode_change;

    mod_n_tick #(
        .N (SEC_PER_MIN),
        .W (SEC_W)
    ) u_seconds (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (presc_last),
        .clr_i   (sec_clr_all),
        .count_o (seconds),
        .wrap_o  (sec_wrap)
    );

    // ------------------------------------------------------------------
    // Minute pulse
    // ------------------------------------------------------------------
    // In fast mode every second tick is also a minute tick. The decision
    // uses the mode already registered before the tick edge, so a
    // fast->normal switch on a tick edge still produces this pulse.
    logic fast_min_d;
    logic fast_min_q;

    assign fast_min_d = presc_last & fast_q & ~sec_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fast_min_q <= 1'b0;
        end else begin
            fast_min_q <= fast_min_d;
        end
    end

    // Both sources are flops and never high together: the seconds counter
    // cannot wrap while fast_q holds it cleared.
    assign one_minute = sec_wrap | fast_min_q;

endmodule : minute_tick_gen

// File: tb/tb_minute_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_minute_tick_gen
//
// dut_a runs with CLK_HZ=4, SEC_PER_MIN=3 and is checked every cycle against
// a behavioural model built from edge counting and a mode-delay queue.
// dut_b runs with the default 256/60 setting and is checked during the first
// 520 cycles after reset release for the 1 Hz tick position.
// -----------------------------------------------------------------------------
module tb_minute_tick_gen;

    localparam int CLK_A = 4;
    localparam int SEC_A = 3;
    localparam int CLK_B = 256;
    localparam int SEC_B = 60;

`ifdef MINUTE_TICK_GEN_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       reset_n;
    logic       fast_watch;
    logic       sec_clr;
    logic       one_second_a;
    logic       one_minute_a;
    logic [5:0] seconds_a;

    logic       fast_watch_b;
    logic       sec_clr_b;
    logic       one_second_b;
    logic       one_minute_b;
    logic [5:0] seconds_b;

    minute_tick_gen #(
        .CLK_HZ      (CLK_A),
        .SEC_PER_MIN (SEC_A)
    ) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .fast_watch (fast_watch),
        .sec_clr    (sec_clr),
        .one_second (one_second_a),
        .one_minute (one_minute_a),
        .seconds    (seconds_a)
    );

    minute_tick_gen dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .fast_watch (fast_watch_b),
        .sec_clr    (sec_clr_b),
        .one_second (one_second_b),
        .one_minute (one_minute_b),
        .seconds    (seconds_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- behavioural model of dut_a ----------------
    int m_edges;           // edges since last alignment (reset release / sec_clr)
    int m_secs;
    bit m_mode;            // mode in effect before the next edge
    bit fw_hist[$];        // fast_watch samples still travelling to the mode register
    bit exp_sec;
    bit exp_min;

    task automatic model_reset();
        m_edges = 0;
        m_secs  = 0;
        m_mode  = 1'b0;
        exp_sec = 1'b0;
        exp_min = 1'b0;
        fw_hist.delete();
        for (int i = 0; i < LAT - 1; i++) fw_hist.push_back(1'b0);
    endtask

    task automatic model_edge(input bit fw, input bit clr);
        bit new_mode;
        bit tick;
        fw_hist.push_back(fw);
        new_mode = fw_hist.pop_front();
        exp_min  = 1'b0;
        if (clr) begin
            m_edges = 0;
            m_secs  = 0;
            exp_sec = 1'b0;
        end else begin
            m_edges++;
            tick    = (m_edges % CLK_A) == 0;
            exp_sec = tick;
            if (new_mode != m_mode) begin
                exp_min = tick && m_mode;
                m_secs  = 0;
            end else if (m_mode) begin
                exp_min = tick;
                m_secs  = 0;
            end else if (tick) begin
                if (m_secs == SEC_A - 1) begin
                    m_secs  = 0;
                    exp_min = 1'b1;
                end else begin
                    m_secs++;
                end
            end
        end
        m_mode = new_mode;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, check on the falling edge.
    task automatic step(input bit fw, input bit clr);
        fast_watch = fw;
        sec_clr    = clr;
        @(posedge clk);
        cyc++;
        model_edge(fw, clr);
        @(negedge clk);
        $display("cyc %0d fw=%0b clr=%0b | sec=%0b min=%0b s=%0d", cyc, fw, clr,
                 one_second_a, one_minute_a, seconds_a);
        chk("a_one_second", one_second_a, exp_sec);
        chk("a_one_minute", one_minute_a, exp_min);
        chk("a_seconds",    seconds_a,    m_secs);
    endtask

    bit fw_r;
    bit clr_r;

    initial begin
        reset_n      = 1'b0;
        fast_watch   = 1'b0;
        sec_clr      = 1'b0;
        fast_watch_b = 1'b0;
        sec_clr_b    = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_a_one_second", one_second_a, 0);
        chk("rst_a_one_minute", one_minute_a, 0);
        chk("rst_a_seconds",    seconds_a,    0);
        chk("rst_b_one_second", one_second_b, 0);
        chk("rst_b_seconds",    seconds_b,    0);
        reset_n = 1'b1;

        // Normal run on both instances; dut_b checks the 256-cycle tick.
        for (int n = 1; n <= 520; n++) begin
            step(1'b0, 1'b0);
            chk("b_one_second", one_second_b, (n % CLK_B) == 0);
            chk("b_one_minute", one_minute_b, 0);
            chk("b_seconds",    seconds_b,    (n / CLK_B) % SEC_B);
        end

        // Fast-watch on, then off.
        repeat (20) step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0);

        // sec_clr on the edge that would produce a tick.
        for (int i = 0; i < 10 && (m_edges % CLK_A) != CLK_A - 1; i++) step(1'b0, 1'b0);
        chk("align_before_clr", (m_edges % CLK_A), CLK_A - 1);
        step(1'b0, 1'b1);
        repeat (3 * CLK_A + 2) step(1'b0, 1'b0);

        // Asynchronous reset mid-minute at seconds == 2.
        for (int i = 0; i < 40 && m_secs != 2; i++) step(1'b0, 1'b0);
        chk("seconds_before_reset", seconds_a, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_one_second", one_second_a, 0);
        chk("async_rst_one_minute", one_minute_a, 0);
        chk("async_rst_seconds",    seconds_a,    0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        repeat (2 * CLK_A + 1) step(1'b0, 1'b0);

        // Randomized traffic: occasional mode toggles and clears.
        fw_r = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 24) == 0) fw_r = ~fw_r;
            clr_r = ($urandom_range(0, 39) == 0);
            step(fw_r, clr_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_minute_tick_gen
